// File: rtl/aes_spi_frontend.sv
// SPI slave front end for the AES core: frame = key then one plaintext block, ciphertext returned next frame.
// Latency: key/block load 1 clk after the synchronised cs rise; ciphertext captured CIPHER_LAT clk later.
// Backpressure: frames that arrive while a capture is pending are ignored and flagged; sclk <= clk/8.
`timescale 1ns/1ps
module aes_spi_frontend #(
  parameter int NK         = 8,
  parameter int CIPHER_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic [0:32*NK-1]  key_out,
  output logic [0:127]      block_out,
  input  logic [0:127]      cipher_in,
  output logic              ct_valid,
  output logic              busy,
  output logic              frame_err
);

  localparam int KW    = 32 * NK;
  localparam int FRAME = KW + 128;
  localparam int CW    = $clog2(FRAME + 2);
  localparam int LW    = $clog2(CIPHER_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WAIT, S_IGNORE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        sclk_q;
  logic [2:0]        cs_q;
  logic [1:0]        mosi_q;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [0:FRAME-1]  rx_q, rx_d;
  logic [0:KW-1]     key_q, key_d;
  logic [0:127]      blk_q, blk_d;
  logic [0:127]      ct_q, ct_d;
  logic [0:127]      tx_q, tx_d;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_low, mosi_s;
  logic accept, rx_bit, tx_bit, frame_start;

  // Two-flop synchronisers plus one history flop for edge detection; cs idles high out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 3'b000;
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      cs_q   <= {cs_q[1:0], cs_n};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_low    = ~cs_q[1];
  assign mosi_s    = mosi_q[1];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; a pending capture keeps counting even after leaving WAIT for IGNORE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cs_fall) state_d = S_RECV;
      S_RECV:   if (cs_rise) state_d = (bit_cnt_q == CW'(FRAME)) ? S_WAIT : S_IDLE;
      S_WAIT: begin
        if (cs_fall)              state_d = S_IGNORE;
        else if (lat_q == LW'(1)) state_d = S_IDLE;
      end
      S_IGNORE: if (cs_rise) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs and datapath strobes
  always_comb begin
    accept      = (state_q == S_RECV) && cs_rise && (bit_cnt_q == CW'(FRAME));
    frame_err   = ((state_q == S_RECV) && cs_rise && (bit_cnt_q != CW'(FRAME))) ||
                  ((state_q == S_IGNORE) && cs_rise);
    busy        = (state_q == S_WAIT);
    ct_valid    = (lat_q == LW'(1));
    rx_bit      = (state_q == S_RECV) && cs_low && sclk_rise;
    tx_bit      = (state_q == S_RECV) && cs_low && sclk_fall;
    frame_start = (state_q == S_IDLE) && cs_fall;
    miso        = cs_low ? tx_q[0] : 1'b0;
  end

  // Datapath next state: shift-in, atomic key/block load, settle countdown, capture and shift-out
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    key_d     = key_q;
    blk_d     = blk_q;
    lat_d     = lat_q;
    ct_d      = ct_q;
    tx_d      = tx_q;
    if (frame_start) begin
      bit_cnt_d = '0;
    end else if (rx_bit) begin
      rx_d = {rx_q[1:FRAME-1], mosi_s};
      if (bit_cnt_q != CW'(FRAME + 1)) bit_cnt_d = bit_cnt_q + 1'b1;
    end
    if (accept) begin
      key_d = rx_q[0:KW-1];
      blk_d = rx_q[KW:FRAME-1];
      lat_d = LW'(CIPHER_LAT);
    end else if (lat_q != '0) begin
      lat_d = lat_q - 1'b1;
    end
    // The held ciphertext is reloaded at every frame start so repeated reads return the same value
    if (lat_q == LW'(1)) begin
      ct_d = cipher_in;
      tx_d = cipher_in;
    end else if (frame_start) begin
      tx_d = ct_q;
    end else if (tx_bit) begin
      tx_d = {tx_q[1:127], 1'b0};
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      rx_q      <= '0;
      key_q     <= '0;
      blk_q     <= '0;
      lat_q     <= '0;
      ct_q      <= '0;
      tx_q      <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      key_q     <= key_d;
      blk_q     <= blk_d;
      lat_q     <= lat_d;
      ct_q      <= ct_d;
      tx_q      <= tx_d;
    end
  end

  assign key_out   = key_q;
  assign block_out = blk_q;

endmodule

// File: tb/tb_aes_spi_frontend.sv
// Directed bench for aes_spi_frontend: AES-256 instance (NK=8) and AES-128 instance (NK=4).
// Cipher modelled combinationally from the FIPS-197 example vectors.
// SPI master runs at clk/10 (50 ns half period).
`timescale 1ns/1ps
module tb_aes_spi_frontend;

  localparam logic [0:255] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [0:127] K128  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [0:127] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic mosi = 1'b0;
  logic cs_n8 = 1'b1;
  logic cs_n4 = 1'b1;
  logic miso8, miso4, ctv8, ctv4, busy8, busy4, err8, err4;
  logic [0:255] key8;
  logic [0:127] blk8, cin8, key4, blk4, cin4;

  int total = 0;
  int passed = 0;
  int n_ct8 = 0, n_err8 = 0, n_busy8 = 0, n_ct4 = 0, n_err4 = 0;

  logic [0:511] din, din4, dout;

  always #5 clk = ~clk;

  assign cin8 = (key8 === K256 && blk8 === PT) ? CT256 : (key8[0:127] ^ blk8);
  assign cin4 = (key4 === K128 && blk4 === PT) ? CT128 : (key4 ^ blk4);

  aes_spi_frontend #(.NK(8), .CIPHER_LAT(2)) u8 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n8), .mosi(mosi), .miso(miso8),
    .key_out(key8), .block_out(blk8), .cipher_in(cin8),
    .ct_valid(ctv8), .busy(busy8), .frame_err(err8)
  );

  aes_spi_frontend #(.NK(4), .CIPHER_LAT(2)) u4 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n4), .mosi(mosi), .miso(miso4),
    .key_out(key4), .block_out(blk4), .cipher_in(cin4),
    .ct_valid(ctv4), .busy(busy4), .frame_err(err4)
  );

  // Pulse/level counters sampled away from the active edge
  always @(negedge clk) begin
    if (ctv8)  n_ct8++;
    if (err8)  n_err8++;
    if (busy8) n_busy8++;
    if (ctv4)  n_ct4++;
    if (err4)  n_err4++;
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Mode-0 master: MOSI set while sclk low, MISO sampled just before each rising edge
  task automatic xfer(input bit sel, input int nbits, input logic [0:511] d,
                      input bit keep_low, output logic [0:511] q);
    q = '0;
    if (sel) cs_n4 = 1'b0; else cs_n8 = 1'b0;
    #50;
    for (int i = 0; i < nbits; i++) begin
      mosi = d[i];
      #50;
      q[i] = sel ? miso4 : miso8;
      sclk = 1'b1;
      #50;
      sclk = 1'b0;
    end
    if (!keep_low) begin
      #50;
      if (sel) cs_n4 = 1'b1; else cs_n8 = 1'b1;
      #200;
    end
  endtask

  initial begin
    din  = {K256, PT, 128'h0};
    din4 = {K128, PT, 256'h0};

    // Reset state
    #33;
    check("rst_miso",   512'(miso8), 512'(1'b0));
    check("rst_key",    512'(key8),  512'(0));
    check("rst_block",  512'(blk8),  512'(0));
    check("rst_ctv",    512'(ctv8),  512'(1'b0));
    check("rst_busy",   512'(busy8), 512'(1'b0));
    check("rst_err",    512'(err8),  512'(1'b0));
    #20 rst_n = 1'b1;
    #100;

    // Valid AES-256 frame
    xfer(1'b0, 384, din, 1'b0, dout);
    check("t1_key",     512'(key8),    512'(K256));
    check("t1_block",   512'(blk8),    512'(PT));
    check("t1_ct_cnt",  512'(n_ct8),   512'(1));
    check("t1_busy_cy", 512'(n_busy8), 512'(2));
    check("t1_err_cnt", 512'(n_err8),  512'(0));

    // Short and long frames: both rejected, both still read back the held ciphertext
    xfer(1'b0, 383, ~din, 1'b0, dout);
    check("t2_read1_ct", 512'(dout[0:127]), 512'(CT256));
    xfer(1'b0, 385, ~din, 1'b0, dout);
    check("t2_read2_ct",  512'(dout[0:127]),   512'(CT256));
    check("t6_tail_zero", 512'(dout[128:384]), 512'(0));
    check("t2_err_cnt",   512'(n_err8), 512'(2));
    check("t2_ct_cnt",    512'(n_ct8),  512'(1));
    check("t2_key",       512'(key8),   512'(K256));
    check("t2_block",     512'(blk8),   512'(PT));

    // Frame starting one clk after an accepted frame ends
    xfer(1'b0, 384, din, 1'b1, dout);
    #50 cs_n8 = 1'b1;
    #10;
    xfer(1'b0, 16, ~din, 1'b0, dout);
    check("t3_ct_cnt",  512'(n_ct8),   512'(2));
    check("t3_err_cnt", 512'(n_err8),  512'(3));
    check("t3_busy_cy", 512'(n_busy8), 512'(3));
    check("t3_key",     512'(key8),    512'(K256));
    xfer(1'b0, 16, 512'h0, 1'b0, dout);
    check("t3_read_ct", 512'(dout[0:15]), 512'(16'h8ea2));
    check("t3_err_cnt2", 512'(n_err8), 512'(4));

    // Reset mid-frame
    xfer(1'b0, 100, din, 1'b1, dout);
    #20 rst_n = 1'b0;
    #20;
    check("t4_rst_key",   512'(key8),  512'(0));
    check("t4_rst_block", 512'(blk8),  512'(0));
    check("t4_rst_miso",  512'(miso8), 512'(1'b0));
    check("t4_rst_busy",  512'(busy8), 512'(1'b0));
    cs_n8 = 1'b1;
    #50 rst_n = 1'b1;
    #100;
    check("t4_err_cnt", 512'(n_err8), 512'(4));
    check("t4_ct_cnt",  512'(n_ct8),  512'(2));
    xfer(1'b0, 384, din, 1'b0, dout);
    check("t4_key",     512'(key8),  512'(K256));
    check("t4_block",   512'(blk8),  512'(PT));
    check("t4_ct_cnt2", 512'(n_ct8), 512'(3));
    xfer(1'b0, 128, 512'h0, 1'b0, dout);
    check("t4_read_ct", 512'(dout[0:127]), 512'(CT256));

    // AES-128 instance
    xfer(1'b1, 256, din4, 1'b0, dout);
    check("t5_key",    512'(key4),  512'(K128));
    check("t5_block",  512'(blk4),  512'(PT));
    check("t5_ct_cnt", 512'(n_ct4), 512'(1));
    xfer(1'b1, 128, 512'h0, 1'b0, dout);
    check("t5_read_ct", 512'(dout[0:127]), 512'(CT128));
    check("t5_err_cnt", 512'(n_err4), 512'(1));
    check("t5_u8_idle", 512'(n_ct8),  512'(3));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
